// File: rtl/memory_pkg.sv
// memory_pkg
// Shared definitions for the simple-dual-port RAM (memory_dp) and its
// self-clearing controller (memory_clear_fsm).
//   state_t     : controller states ST_CLEAR / ST_IDLE
//   LANE_WIDTH  : bits per byte lane
//   even_parity : parity bit that makes a byte plus its parity hold an even
//                 number of ones

package memory_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam int LANE_WIDTH = 8;

    function automatic logic even_parity(input logic [LANE_WIDTH-1:0] lane);
        return ^lane;
    endfunction

endpackage

// File: rtl/memory_clear_fsm.sv
// memory_clear_fsm
// Walks a pointer across the whole array after reset or a clr pulse so the
// RAM can be zeroed one word per cycle, and reports busy while doing so.
// Ports:
//   clk        in  clock, rising edge
//   rst        in  asynchronous active-high reset (restarts the clear)
//   clr        in  restart the clear sequence from address 0
//   busy       out high while the clear sequence runs
//   clear_we   out write-zero strobe for the array
//   clear_addr out address being zeroed this cycle

module memory_clear_fsm #(
    parameter int ADDRESS_WIDTH = 4,
    parameter int RAM_DEPTH     = 1 << ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    output logic                     busy,
    output logic                     clear_we,
    output logic [ADDRESS_WIDTH-1:0] clear_addr
);
    import memory_pkg::*;

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(RAM_DEPTH - 1);

    state_t                   state;
    state_t                   state_next;
    logic [ADDRESS_WIDTH-1:0] ptr;
    logic [ADDRESS_WIDTH-1:0] ptr_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    // The last word is zeroed on the same edge that enters IDLE, so busy is
    // high for exactly RAM_DEPTH cycles. A clr while clearing rewinds the
    // pointer, stretching busy to a full sweep from that pulse.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        busy       = 1'b0;
        clear_we   = 1'b0;
        clear_addr = ptr;
        case (state)
            ST_CLEAR: begin
                busy     = 1'b1;
                clear_we = 1'b1;
                if (clr) begin
                    ptr_next = '0;
                end else if (ptr == LAST_ADDR) begin
                    state_next = ST_IDLE;
                    ptr_next   = '0;
                end else begin
                    ptr_next = ptr + 1'b1;
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    state_next = ST_CLEAR;
                    ptr_next   = '0;
                end
            end
        endcase
    end

endmodule

// File: rtl/memory_dp.sv
// memory_dp
// Parametrised simple-dual-port RAM with per-byte write enables, a
// registered read (1-cycle latency) with a valid strobe, selectable
// read-during-write behaviour (BYPASS) and a self-clearing array.
// Optional feature macro: MEMORY_PARITY_EN (per-lane even parity storage,
// wr_perr_inject input and rd_perr output).
// Ports:
//   clk, rst          clock / asynchronous active-high reset
//   clr               restart the array clear sequence
//   busy              clear sequence running; user accesses ignored
//   wr_en, wr_addr, wr_be, wr_data   write port
//   rd_en, rd_addr    read request
//   rd_data, rd_valid registered read data and its one-cycle strobe
//   wr_perr_inject    (parity build) invert stored parity of enabled lanes
//   rd_perr           (parity build) stored parity mismatch on the read word

module memory_dp #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 4,
    parameter int RAM_DEPTH     = 1 << ADDRESS_WIDTH,
    // Derived lane count; leave at its default.
    parameter int BE_WIDTH      = DATA_WIDTH / 8,
    parameter bit BYPASS        = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    output logic                     busy,
    input  logic                     wr_en,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [BE_WIDTH-1:0]      wr_be,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     rd_en,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_valid
`ifdef MEMORY_PARITY_EN
    ,
    input  logic                     wr_perr_inject,
    output logic                     rd_perr
`endif
);
    import memory_pkg::*;

    logic                     clear_we;
    logic [ADDRESS_WIDTH-1:0] clear_addr;
    logic                     user_wr;
    logic                     user_rd;
    logic                     same_addr;
    logic [DATA_WIDTH-1:0]    mem [RAM_DEPTH];
    logic [DATA_WIDTH-1:0]    wr_merged;
    logic [DATA_WIDTH-1:0]    rd_word;

    memory_clear_fsm #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .RAM_DEPTH     (RAM_DEPTH)
    ) u_clear_fsm (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .busy       (busy),
        .clear_we   (clear_we),
        .clear_addr (clear_addr)
    );

    // clr takes priority over a same-cycle access, and nothing from the user
    // ports reaches the array or the read register while clearing.
    assign user_wr   = wr_en & ~busy & ~clr;
    assign user_rd   = rd_en & ~busy & ~clr;
    assign same_addr = user_wr & (wr_addr == rd_addr);

    // The word as it will look after this cycle's write; reused as the
    // bypass value for a same-address read.
    always_comb begin
        wr_merged = mem[wr_addr];
        for (int b = 0; b < BE_WIDTH; b++) begin
            if (wr_be[b]) begin
                wr_merged[b*LANE_WIDTH +: LANE_WIDTH] = wr_data[b*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    always_comb begin
        if (BYPASS && same_addr) begin
            rd_word = wr_merged;
        end else begin
            rd_word = mem[rd_addr];
        end
    end

    // The array itself is never reset; the clear sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem[clear_addr] <= '0;
        end else if (user_wr) begin
            mem[wr_addr] <= wr_merged;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= user_rd;
            if (user_rd) begin
                rd_data <= rd_word;
            end
        end
    end

`ifdef MEMORY_PARITY_EN
    logic [BE_WIDTH-1:0] par_mem [RAM_DEPTH];
    logic [BE_WIDTH-1:0] wr_par_merged;
    logic [BE_WIDTH-1:0] rd_par_word;
    logic [BE_WIDTH-1:0] rd_par_calc;

    // Parity of enabled lanes is recomputed from the new data; the inject
    // input flips it so error paths can be exercised on demand.
    always_comb begin
        wr_par_merged = par_mem[wr_addr];
        for (int b = 0; b < BE_WIDTH; b++) begin
            if (wr_be[b]) begin
                wr_par_merged[b] = even_parity(wr_data[b*LANE_WIDTH +: LANE_WIDTH]) ^ wr_perr_inject;
            end
        end
    end

    always_comb begin
        rd_par_calc = '0;
        if (BYPASS && same_addr) begin
            rd_par_word = wr_par_merged;
        end else begin
            rd_par_word = par_mem[rd_addr];
        end
        for (int b = 0; b < BE_WIDTH; b++) begin
            rd_par_calc[b] = even_parity(rd_word[b*LANE_WIDTH +: LANE_WIDTH]);
        end
    end

    always_ff @(posedge clk) begin
        if (clear_we) begin
            par_mem[clear_addr] <= '0;
        end else if (user_wr) begin
            par_mem[wr_addr] <= wr_par_merged;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_perr <= 1'b0;
        end else if (user_rd) begin
            rd_perr <= |(rd_par_calc ^ rd_par_word);
        end
    end
`endif

endmodule

// File: tb/tb_memory_dp.sv
// tb_memory_dp
// Drives two memory_dp instances (BYPASS=1 and BYPASS=0) with identical
// directed stimulus and compares both against a word-level model every
// cycle, plus hand-computed expectations at key points.

module tb_memory_dp;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic        inject;

    logic        busy_a;
    logic [31:0] rd_data_a;
    logic        rd_valid_a;
    logic        busy_b;
    logic [31:0] rd_data_b;
    logic        rd_valid_b;
`ifdef MEMORY_PARITY_EN
    logic        rd_perr_a;
    logic        rd_perr_b;
`endif

    int tests_run;
    int tests_failed;

    memory_dp #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (4),
        .BYPASS        (1'b1)
    ) u_dut_new (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .busy     (busy_a),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_be    (wr_be),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data_a),
        .rd_valid (rd_valid_a)
`ifdef MEMORY_PARITY_EN
        ,
        .wr_perr_inject (inject),
        .rd_perr        (rd_perr_a)
`endif
    );

    memory_dp #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (4),
        .BYPASS        (1'b0)
    ) u_dut_old (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .busy     (busy_b),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_be    (wr_be),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data_b),
        .rd_valid (rd_valid_b)
`ifdef MEMORY_PARITY_EN
        ,
        .wr_perr_inject (inject),
        .rd_perr        (rd_perr_b)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: memory contents as plain words, clear progress as a
    // count of remaining busy cycles.
    logic [31:0] model_mem [16];
    int          clear_left;
    logic        exp_busy;
    logic        exp_valid;
    logic [31:0] exp_data_a;
    logic [31:0] exp_data_b;
`ifdef MEMORY_PARITY_EN
    logic [3:0]  model_par [16];
    logic        exp_perr_a;
    logic        exp_perr_b;
`endif

    function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [31:0] data,
                                               input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = data[8*b +: 8];
        end
        return r;
    endfunction

`ifdef MEMORY_PARITY_EN
    function automatic logic [3:0] lane_parity(input logic [31:0] w);
        logic [3:0] p;
        for (int b = 0; b < 4; b++) p[b] = ^w[8*b +: 8];
        return p;
    endfunction

    function automatic logic [3:0] merge_par(input logic [3:0] old, input logic [31:0] data,
                                             input logic [3:0] be, input logic inj);
        logic [3:0] p;
        p = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) p[b] = (^data[8*b +: 8]) ^ inj;
        end
        return p;
    endfunction
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            clear_left <= 16;
            exp_busy   <= 1'b1;
            exp_valid  <= 1'b0;
            exp_data_a <= 32'h0;
            exp_data_b <= 32'h0;
`ifdef MEMORY_PARITY_EN
            exp_perr_a <= 1'b0;
            exp_perr_b <= 1'b0;
`endif
        end else if (clear_left != 0) begin
            exp_valid <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                model_mem[i] <= 32'h0;
`ifdef MEMORY_PARITY_EN
                model_par[i] <= 4'h0;
`endif
            end
            if (clr) begin
                clear_left <= 16;
                exp_busy   <= 1'b1;
            end else begin
                clear_left <= clear_left - 1;
                exp_busy   <= (clear_left != 1);
            end
        end else if (clr) begin
            clear_left <= 16;
            exp_busy   <= 1'b1;
            exp_valid  <= 1'b0;
        end else begin
            exp_valid <= rd_en;
            if (rd_en) begin
                exp_data_b <= model_mem[rd_addr];
                exp_data_a <= (wr_en && wr_addr == rd_addr)
                              ? merge_word(model_mem[rd_addr], wr_data, wr_be)
                              : model_mem[rd_addr];
`ifdef MEMORY_PARITY_EN
                exp_perr_b <= |(lane_parity(model_mem[rd_addr]) ^ model_par[rd_addr]);
                exp_perr_a <= (wr_en && wr_addr == rd_addr)
                    ? |(lane_parity(merge_word(model_mem[rd_addr], wr_data, wr_be))
                        ^ merge_par(model_par[rd_addr], wr_data, wr_be, inject))
                    : |(lane_parity(model_mem[rd_addr]) ^ model_par[rd_addr]);
`endif
            end
            if (wr_en) begin
                model_mem[wr_addr] <= merge_word(model_mem[wr_addr], wr_data, wr_be);
`ifdef MEMORY_PARITY_EN
                model_par[wr_addr] <= merge_par(model_par[wr_addr], wr_data, wr_be, inject);
`endif
            end
        end
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput();
        check("busy_new", 32'(busy_a), 32'(exp_busy));
        check("busy_old", 32'(busy_b), 32'(exp_busy));
        check("rd_valid_new", 32'(rd_valid_a), 32'(exp_valid));
        check("rd_valid_old", 32'(rd_valid_b), 32'(exp_valid));
        check("rd_data_new", rd_data_a, exp_data_a);
        check("rd_data_old", rd_data_b, exp_data_b);
`ifdef MEMORY_PARITY_EN
        if (exp_valid) begin
            check("rd_perr_new", 32'(rd_perr_a), 32'(exp_perr_a));
            check("rd_perr_old", 32'(rd_perr_b), 32'(exp_perr_b));
        end
`endif
    endtask

    // Every cycle, away from the active edge.
    always @(negedge clk) begin
        checkOutput();
    end

    // Present one cycle of inputs, let the edge take them, then drop strobes.
    task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [3:0] be,
                                 input logic [31:0] wd, input logic re, input logic [3:0] ra,
                                 input logic c, input logic inj);
        wr_en   = we;
        wr_addr = wa;
        wr_be   = be;
        wr_data = wd;
        rd_en   = re;
        rd_addr = ra;
        clr     = c;
        inject  = inj;
        @(posedge clk);
        #1;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        clr    = 1'b0;
        inject = 1'b0;
    endtask

    // Count cycles until busy drops, optionally hammering the ports with
    // accesses to address 0 the whole time. Bounded so it cannot hang.
    task automatic countBusy(output int n, input logic with_access);
        n = 0;
        while (busy_a && n < 100) begin
            applyStimulus(with_access, 4'd0, 4'hF, 32'hFFFFFFFF, with_access, 4'd0, 1'b0, 1'b0);
            n++;
        end
    endtask

    int n;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst     = 1'b0;
        clr     = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 4'd0;
        wr_be   = 4'h0;
        wr_data = 32'h0;
        rd_en   = 1'b0;
        rd_addr = 4'd0;
        inject  = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy_a), 32'h1);
        check("reset_valid", 32'(rd_valid_a), 32'h0);
        check("reset_data", rd_data_a, 32'h0);
        rst = 1'b0;

        countBusy(n, 1'b0);
        check("busy_after_reset_cycles", 32'(n), 32'd16);

        for (int a = 0; a < 16; a++) begin
            applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'(a), 1'b0, 1'b0);
            check("cleared_read_valid", 32'(rd_valid_a), 32'h1);
            check("cleared_read_data", rd_data_a, 32'h0);
        end

        // Byte-lane merge.
        applyStimulus(1'b1, 4'd3, 4'hF, 32'hDEADBEEF, 1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd3, 4'h5, 32'h11223344, 1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd3, 1'b0, 1'b0);
        check("lane_merge_addr3", rd_data_a, 32'hDE22BE44);

        // Same-address collision: new data vs old data.
        applyStimulus(1'b1, 4'd5, 4'hF, 32'hAAAAAAAA, 1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd5, 4'h3, 32'h12345678, 1'b1, 4'd5, 1'b0, 1'b0);
        check("collision_bypass", rd_data_a, 32'hAAAA5678);
        check("collision_old", rd_data_b, 32'hAAAAAAAA);
        applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd5, 1'b0, 1'b0);
        check("after_collision_old", rd_data_b, 32'hAAAA5678);

        // Different-address same-cycle access, then a wr_be=0 no-op.
        applyStimulus(1'b1, 4'd7, 4'hF, 32'h01020304, 1'b1, 4'd3, 1'b0, 1'b0);
        check("diff_addr_read", rd_data_a, 32'hDE22BE44);
        applyStimulus(1'b1, 4'd7, 4'h0, 32'hFFFFFFFF, 1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd7, 1'b0, 1'b0);
        check("diff_addr_write", rd_data_a, 32'h01020304);

        // Reads with rd_en low hold the data.
        applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd3, 1'b0, 1'b0);
        check("hold_valid", 32'(rd_valid_a), 32'h0);
        check("hold_data", rd_data_a, 32'h01020304);

        // clr with a same-cycle write: write dropped, full clear.
        applyStimulus(1'b1, 4'd2, 4'hF, 32'hCAFEF00D, 1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd2, 4'hF, 32'h12345678, 1'b0, 4'd0, 1'b1, 1'b0);
        countBusy(n, 1'b0);
        check("busy_after_clr_cycles", 32'(n), 32'd16);
        applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd2, 1'b0, 1'b0);
        check("addr2_cleared", rd_data_a, 32'h0);

        // clr again at ptr=7 while accesses are attempted during busy.
        applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 4'd0, 4'hF, 32'hFFFFFFFF, 1'b1, 4'd0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0);
        countBusy(n, 1'b1);
        check("busy_after_midclear_clr", 32'(n), 32'd16);
        applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd0, 1'b0, 1'b0);
        check("busy_access_ignored", rd_data_a, 32'h0);

`ifdef MEMORY_PARITY_EN
        applyStimulus(1'b1, 4'd9, 4'h2, 32'h0F0F0F0F, 1'b0, 4'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd9, 1'b0, 1'b0);
        check("perr_injected_valid", 32'(rd_valid_a), 32'h1);
        check("perr_injected", 32'(rd_perr_a), 32'h1);
        applyStimulus(1'b1, 4'd9, 4'hF, 32'h0F0F0F0F, 1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd9, 1'b0, 1'b0);
        check("perr_cleared", 32'(rd_perr_a), 32'h0);
        applyStimulus(1'b1, 4'd9, 4'h1, 32'h00000001, 1'b1, 4'd9, 1'b0, 1'b1);
`endif

        // Asynchronous reset while a read is in flight.
        applyStimulus(1'b1, 4'd6, 4'hF, 32'h0BADF00D, 1'b0, 4'd0, 1'b0, 1'b0);
        rd_en   = 1'b1;
        rd_addr = 4'd6;
        @(posedge clk);
        #1;
        check("pre_reset_data", rd_data_a, 32'h0BADF00D);
        #2 rst = 1'b1;
        #1;
        check("async_reset_valid", 32'(rd_valid_a), 32'h0);
        check("async_reset_data", rd_data_a, 32'h0);
        check("async_reset_busy", 32'(busy_a), 32'h1);
        rd_en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        countBusy(n, 1'b0);
        check("busy_after_rereset", 32'(n), 32'd16);
        applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd6, 1'b0, 1'b0);
        check("addr6_cleared", rd_data_a, 32'h0);

        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/memory_dp.md
Name: memory_dp

Overview:
Parametrised simple-dual-port RAM; successor to the single-port inout-bus memory.
- Independent write and read ports, so one write and one read can complete in the same cycle.
- Per-byte write enables and a registered read with a valid strobe.
- Configurable read-during-write collision behaviour.
- Self-clearing state machine zeroes the array after reset or on request.
- Serves as the UART's TX/RX buffer and configuration store.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8
ADDRESS_WIDTH, 4, address bits
RAM_DEPTH, 1<<ADDRESS_WIDTH, number of words
BE_WIDTH, DATA_WIDTH/8, byte-lane count (derived; not to be overridden)
BYPASS, 1, same-address read/write: 1 returns new data, 0 returns old data

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
clr  in  1  pulse: restart the array clear sequence
busy  out  1  high while clear sequence runs; accesses ignored
wr_en  in  1  write strobe
wr_addr  in  ADDRESS_WIDTH  write address
wr_be  in  BE_WIDTH  byte-lane write enables
wr_data  in  DATA_WIDTH  write data
rd_en  in  1  read strobe
rd_addr  in  ADDRESS_WIDTH  read address
rd_data  out  DATA_WIDTH  registered read data
rd_valid  out  1  one-cycle strobe: rd_data updated this cycle

Behaviour:
- Reset (asynchronous, active-high), while rst high:
  - rd_data=0, rd_valid=0, busy=1.
  - State=CLEAR, clear pointer=0.
  - Array contents are not reset directly; the clear sequence zeroes them.
- States: CLEAR, IDLE.
- CLEAR:
  - Each cycle writes 0 to MEM[ptr], then ptr<=ptr+1.
  - After writing RAM_DEPTH-1, the next state is IDLE.
  - busy is high for exactly RAM_DEPTH cycles after rst release; it falls on the edge that enters IDLE.
  - wr_en and rd_en are ignored; rd_valid stays 0; rd_data holds its value.
- clr:
  - In IDLE: next state CLEAR, ptr=0, busy=1 next cycle.
  - In CLEAR: ptr restarts at 0.
  - clr wins over any same-cycle wr_en/rd_en; those accesses are dropped.
- IDLE write: for each lane b with wr_be[b]=1, MEM[wr_addr][8b+7:8b] <= wr_data lane b; other lanes are unchanged. wr_be=0 is a no-op.
- IDLE read:
  - rd_en=1: next cycle rd_data=MEM[rd_addr] and rd_valid=1. Read latency is 1 cycle.
  - rd_en=0: rd_valid=0 next cycle; rd_data holds its last value.
  - Back-to-back reads every cycle are supported.
- Same-cycle read and write, different addresses: both complete independently.
- Same-cycle read and write, same address:
  - BYPASS=1: rd_data = new data on enabled lanes, old data on disabled lanes.
  - BYPASS=0: rd_data = old word; the write still commits.
- Addresses are full-range. There is no out-of-range check because RAM_DEPTH=2^ADDRESS_WIDTH.
- Reset asserted mid-clear or mid-read: outputs return to reset values immediately, and the clear sequence restarts from 0 after release.

Optional Feature:
MEMORY_PARITY_EN
- Defined:
  - Array stores one even-parity bit per byte lane.
  - Extra input wr_perr_inject (1): when high during a write, the stored parity of enabled lanes is inverted.
  - Extra output rd_perr (1): registered alongside rd_data; high with rd_valid if any lane's stored parity mismatches its data.
  - Clear sequence writes data 0 with parity 0.
  - On a bypassed read, parity is computed from the merged word, including any injected inversion.
  - rd_perr resets to 0.
- Undefined: no parity storage; ports wr_perr_inject and rd_perr do not exist.

Decomposition:
- Shared package/header memory_pkg:
  - State encodings ST_CLEAR and ST_IDLE.
  - Byte-lane width constant 8.
  - Function for even parity of a byte.
- Sub-module memory_clear_fsm:
  - Owns state, ptr, busy and clr handling.
  - Outputs the clear write enable and address.
- memory_dp muxes between clear writes and user writes and holds the array and read path.

Test Plan (DATA_WIDTH=32, ADDRESS_WIDTH=4):
- Reset release -> busy high for exactly 16 cycles. Then read all 16 addresses -> rd_data=0x00000000, each rd_valid one cycle after its rd_en.
- Write addr 3, be=4'b1111, 0xDEADBEEF; then write addr 3, be=4'b0101, 0x11223344; read addr 3 -> 0xDE22BE44.
- BYPASS=1: addr 5 holds 0xAAAAAAAA. Same cycle: write 0x12345678 be=4'b0011 and read addr 5 -> rd_data=0xAAAA5678 next cycle. BYPASS=0 -> 0xAAAAAAAA, and a later read returns 0xAAAA5678.
- Pulse clr in IDLE together with a wr_en to addr 2 -> busy 16 cycles, write dropped, addr 2 reads 0. Pulse clr again mid-clear at ptr=7 -> busy extends to 16 cycles from the second pulse.
- rd_en/wr_en during busy -> no rd_valid, array unchanged. Assert rst while rd_en is active -> rd_valid and rd_data go to 0 without waiting for a clock edge.
- MEMORY_PARITY_EN:
  - Write addr 9, 0x0F0F0F0F, be=4'b0010, wr_perr_inject=1; read addr 9 -> rd_perr=1 with rd_valid.
  - Rewrite addr 9, be=4'b1111, inject=0; read addr 9 -> rd_perr=0.
